di_arbiter: RTL and testbench
=============================

# di_arbiter

Two-master arbiter for the device-interface register bus. It lets the host interface (master A) and an on-chip sequencer (master B) share one downstream set of endpoint and register lines, and the read/write strobes that go with them. It sits between the host-interface block and the endpoint/terminal decode logic. Grants are round-robin, locked for as long as the owner holds its request. An optional watchdog revokes a stalled owner.

## Interface
- HOLD_TIMEOUT, 1024: idle-owner cycles before forced release (watchdog build only); legal range 2..65535.
- if_clock  in  1  sole clock; all state changes on rising edge.
- resetb  in  1  synchronous, active-low reset.
- a_req, b_req  in  1  bus request, level; held high for the whole ownership.
- a_gnt, b_gnt  out  1  grant, registered; never both high.
- a_ep_addr, b_ep_addr  in  16  endpoint address.
- a_reg_addr, b_reg_addr  in  16  register address.
- a_data, b_data  in  16  write data.
- a_write, a_read, a_reset, b_write, b_read, b_reset  in  1  strobes; honoured only while the matching gnt is high.
- a_rd_ready, a_wr_ready, b_rd_ready, b_wr_ready  out  1  downstream ready gated by own gnt.
- rd_data  out  16  = diRegDataOut, broadcast to both masters.
- diEpAddr, diRegAddr, diRegDataIn  out  16  downstream address/data.
- diWrite, diRead, diReset  out  1  downstream strobes.
- diRegDataOut  in  16  downstream read data.
- rd_ready, wr_ready  in  1  downstream readiness.
- arb_owner  out  2  00 none, 01 A, 10 B.
- arb_timeout  out  1  sticky forced-release flag.
- arb_timeout_clr  in  1  clears arb_timeout.

## Operation
- States: IDLE, OWN_A, OWN_B, HANDOVER.
- IDLE:
  - only a_req high -> OWN_A.
  - only b_req high -> OWN_B.
  - both high -> grant the master that is not last_owner.
  - none high -> stay in IDLE.
- OWN_x: stays while x_req is high. When x_req drops, go to HANDOVER and set last_owner = x.
- HANDOVER: lasts exactly one cycle with both grants low, then IDLE. The downstream address therefore never switches owner between adjacent cycles.
- Downstream mux is combinational, selected by the registered grant:
  - OWN_A drives all di* outputs from the a_* inputs; OWN_B from the b_* inputs.
  - IDLE and HANDOVER drive all di* outputs to 0.
- Strobes from a non-granted master are dropped silently. They are not queued.
- x_rd_ready = rd_ready & x_gnt; x_wr_ready = wr_ready & x_gnt.

## Timing
- Reset, while resetb is low at a clock edge:
  - state = IDLE, last_owner = B (so A wins the first tie).
  - a_gnt = b_gnt = 0, arb_owner = 00, arb_timeout = 0, watchdog count = 0.
  - All di* outputs = 0.
- Reset mid-ownership: the grant drops at the next edge. Any in-flight strobe is cut with it.
- Grant latency: request seen high at edge N -> gnt high after edge N (one cycle), unless the arbiter is in HANDOVER or owned by the other master.
- Release latency: req low at edge N -> gnt low after edge N. The earliest re-grant to either master is after edge N+2.
- Strobe-to-downstream latency is 0 cycles, combinational through the mux.
- Simultaneous release by one master and request by the other: HANDOVER is still inserted.
- arb_timeout_clr and a new timeout in the same cycle: the set wins.

## Configuration
- DI_ARB_WATCHDOG_EN defined:
  - A 16-bit count resets to 0 on grant entry and on any granted strobe (write/read/reset). Otherwise it increments by 1 each cycle in OWN_x and saturates at HOLD_TIMEOUT-1.
  - Forced release: when count == HOLD_TIMEOUT-1 and the other master's req is high, go to HANDOVER and set arb_timeout. The timed-out master is marked starved.
  - A starved master is not re-granted until its req has been low for at least one cycle.
  - With no competing request, the count saturates and no release occurs.
- Undefined: no counter and no forced release. arb_timeout is tied 0, arb_timeout_clr is ignored, and HOLD_TIMEOUT is unused.

## Test plan
- Reset, then a_req=1 at cycle 2: a_gnt=1 from cycle 3, arb_owner=01; a_ep_addr=16'h0012 appears on diEpAddr in the same cycle.
- a_req and b_req rise together from IDLE after reset: A granted first. After A drops, one HANDOVER cycle with all di* = 0, then B granted. A second tie goes to A again.
- During OWN_A, b_write=1 with b_data=16'hBEEF: diWrite stays 0 and diRegDataIn shows a_data; b_wr_ready=0.
- Read, wr_ready/rd_ready gating: OWN_B with rd_ready=1 gives b_rd_ready=1 and a_rd_ready=0; diRegDataOut=16'h1234 appears on rd_data in the same cycle.
- Watchdog (DI_ARB_WATCHDOG_EN, HOLD_TIMEOUT=8):
  - A owns with no strobes and b_req high: A is revoked after 8 idle cycles, arb_timeout=1, and B is granted after HANDOVER.
  - A holding req high is not re-granted until it has dropped req.
  - With b_req low, A keeps the grant indefinitely.
- Reset asserted mid-write while OWN_A: diWrite=0 and a_gnt=0 after the reset edge; arb_owner=00.

Source files
------------

// File: rtl/di_arbiter.sv
// rtl/di_arbiter.sv - two-master round-robin arbiter for the device-interface register bus
// Optional stalled-owner watchdog is enabled by defining DI_ARB_WATCHDOG_EN.
module di_arbiter #(
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic        a_req,
  input  logic        b_req,
  output logic        a_gnt,
  output logic        b_gnt,
  input  logic [15:0] a_ep_addr,
  input  logic [15:0] b_ep_addr,
  input  logic [15:0] a_reg_addr,
  input  logic [15:0] b_reg_addr,
  input  logic [15:0] a_data,
  input  logic [15:0] b_data,
  input  logic        a_write,
  input  logic        a_read,
  input  logic        a_reset,
  input  logic        b_write,
  input  logic        b_read,
  input  logic        b_reset,
  output logic        a_rd_ready,
  output logic        a_wr_ready,
  output logic        b_rd_ready,
  output logic        b_wr_ready,
  output logic [15:0] rd_data,
  output logic [15:0] diEpAddr,
  output logic [15:0] diRegAddr,
  output logic [15:0] diRegDataIn,
  output logic        diWrite,
  output logic        diRead,
  output logic        diReset,
  input  logic [15:0] diRegDataOut,
  input  logic        rd_ready,
  input  logic        wr_ready,
  output logic [1:0]  arb_owner,
  output logic        arb_timeout,
  input  logic        arb_timeout_clr
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, HANDOVER} state_t;

  state_t      state_q;
  logic        last_b_q;
  logic        a_gnt_q;
  logic        b_gnt_q;
  logic [1:0]  owner_q;
  logic        a_ok;
  logic        b_ok;
  logic        a_strobe;
  logic        b_strobe;

  assign a_strobe = a_write | a_read | a_reset;
  assign b_strobe = b_write | b_read | b_reset;

`ifdef DI_ARB_WATCHDOG_EN
  localparam logic [15:0] WD_MAX = 16'(HOLD_TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic        timeout_q;
  logic        starved_a_q;
  logic        starved_b_q;

  // A master revoked by the watchdog must drop its request before it can win again.
  assign a_ok = a_req & ~starved_a_q;
  assign b_ok = b_req & ~starved_b_q;
  assign arb_timeout = timeout_q;

  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      owner_q     <= 2'b00;
      cnt_q       <= 16'd0;
      timeout_q   <= 1'b0;
      starved_a_q <= 1'b0;
      starved_b_q <= 1'b0;
    end else begin
      if (arb_timeout_clr) timeout_q <= 1'b0;
      if (!a_req) starved_a_q <= 1'b0;
      if (!b_req) starved_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= 16'd0;
          if (a_ok && (!b_ok || last_b_q)) begin
            state_q <= OWN_A;
            a_gnt_q <= 1'b1;
            owner_q <= 2'b01;
          end else if (b_ok) begin
            state_q <= OWN_B;
            b_gnt_q <= 1'b1;
            owner_q <= 2'b10;
          end
        end
        OWN_A: begin
          if (!a_req || (cnt_q == WD_MAX && b_req)) begin
            state_q  <= HANDOVER;
            a_gnt_q  <= 1'b0;
            owner_q  <= 2'b00;
            last_b_q <= 1'b0;
            if (a_req) begin
              starved_a_q <= 1'b1;
              timeout_q   <= 1'b1;
            end
          end else if (a_strobe) begin
            cnt_q <= 16'd0;
          end else if (cnt_q != WD_MAX) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        OWN_B: begin
          if (!b_req || (cnt_q == WD_MAX && a_req)) begin
            state_q  <= HANDOVER;
            b_gnt_q  <= 1'b0;
            owner_q  <= 2'b00;
            last_b_q <= 1'b1;
            if (b_req) begin
              starved_b_q <= 1'b1;
              timeout_q   <= 1'b1;
            end
          end else if (b_strobe) begin
            cnt_q <= 16'd0;
          end else if (cnt_q != WD_MAX) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  localparam logic [15:0] HOLD_W = 16'(HOLD_TIMEOUT);

  logic unused_cfg;

  assign unused_cfg  = ^{arb_timeout_clr, HOLD_W};
  assign a_ok        = a_req;
  assign b_ok        = b_req;
  assign arb_timeout = 1'b0;

  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      owner_q  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_ok && (!b_ok || last_b_q)) begin
            state_q <= OWN_A;
            a_gnt_q <= 1'b1;
            owner_q <= 2'b01;
          end else if (b_ok) begin
            state_q <= OWN_B;
            b_gnt_q <= 1'b1;
            owner_q <= 2'b10;
          end
        end
        OWN_A: begin
          if (!a_req) begin
            state_q  <= HANDOVER;
            a_gnt_q  <= 1'b0;
            owner_q  <= 2'b00;
            last_b_q <= 1'b0;
          end
        end
        OWN_B: begin
          if (!b_req) begin
            state_q  <= HANDOVER;
            b_gnt_q  <= 1'b0;
            owner_q  <= 2'b00;
            last_b_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign arb_owner  = owner_q;
  assign a_rd_ready = rd_ready & a_gnt_q;
  assign a_wr_ready = wr_ready & a_gnt_q;
  assign b_rd_ready = rd_ready & b_gnt_q;
  assign b_wr_ready = wr_ready & b_gnt_q;
  assign rd_data    = diRegDataOut;

  // Non-granted strobes fall through to zero here; nothing is queued.
  always_comb begin
    diEpAddr    = 16'd0;
    diRegAddr   = 16'd0;
    diRegDataIn = 16'd0;
    diWrite     = 1'b0;
    diRead      = 1'b0;
    diReset     = 1'b0;
    if (a_gnt_q) begin
      diEpAddr    = a_ep_addr;
      diRegAddr   = a_reg_addr;
      diRegDataIn = a_data;
      diWrite     = a_write;
      diRead      = a_read;
      diReset     = a_reset;
    end else if (b_gnt_q) begin
      diEpAddr    = b_ep_addr;
      diRegAddr   = b_reg_addr;
      diRegDataIn = b_data;
      diWrite     = b_write;
      diRead      = b_read;
      diReset     = b_reset;
    end
  end

endmodule

// File: tb/tb_di_arbiter.sv
// tb/tb_di_arbiter.sv - scoreboard bench for di_arbiter against an ownership-level reference model
module tb_di_arbiter;

  localparam int HT = 8;
`ifdef DI_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        if_clock = 1'b0;
  logic        resetb = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic        a_gnt, b_gnt;
  logic [15:0] a_ep_addr = '0, b_ep_addr = '0, a_reg_addr = '0, b_reg_addr = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_write = 0, a_read = 0, a_reset = 0, b_write = 0, b_read = 0, b_reset = 0;
  logic        a_rd_ready, a_wr_ready, b_rd_ready, b_wr_ready;
  logic [15:0] rd_data, diEpAddr, diRegAddr, diRegDataIn;
  logic        diWrite, diRead, diReset;
  logic [15:0] diRegDataOut = '0;
  logic        rd_ready = 0, wr_ready = 0;
  logic [1:0]  arb_owner;
  logic        arb_timeout;
  logic        arb_timeout_clr = 0;

  always #5 if_clock = ~if_clock;

  di_arbiter #(.HOLD_TIMEOUT(HT)) dut (
    .if_clock(if_clock), .resetb(resetb), .a_req(a_req), .b_req(b_req),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_ep_addr(a_ep_addr), .b_ep_addr(b_ep_addr),
    .a_reg_addr(a_reg_addr), .b_reg_addr(b_reg_addr),
    .a_data(a_data), .b_data(b_data),
    .a_write(a_write), .a_read(a_read), .a_reset(a_reset),
    .b_write(b_write), .b_read(b_read), .b_reset(b_reset),
    .a_rd_ready(a_rd_ready), .a_wr_ready(a_wr_ready),
    .b_rd_ready(b_rd_ready), .b_wr_ready(b_wr_ready),
    .rd_data(rd_data), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(diRegDataOut), .rd_ready(rd_ready), .wr_ready(wr_ready),
    .arb_owner(arb_owner), .arb_timeout(arb_timeout), .arb_timeout_clr(arb_timeout_clr)
  );

  typedef struct packed {
    logic        a_gnt, b_gnt, a_rd, a_wr, b_rd, b_wr;
    logic [15:0] rd_data, ep, ra, din;
    logic        wr, rd, rs;
    logic [1:0]  owner;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the bus (0 none, 1 A, 2 B), a pending gap cycle, history.
  int m_owner, m_last, m_cnt;
  bit m_gap, m_to;
  bit m_starv[2];

  function automatic void model_reset();
    m_owner = 0; m_gap = 0; m_last = 2; m_to = 0; m_cnt = 0;
    m_starv[0] = 0; m_starv[1] = 0;
  endfunction

  function automatic void model_step();
    bit ea, eb, mine, other, strobe;
    if (!resetb) begin
      model_reset();
      return;
    end
    if (WD && arb_timeout_clr) m_to = 0;
    if (!a_req) m_starv[0] = 0;
    if (!b_req) m_starv[1] = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner == 0) begin
      ea = a_req && !m_starv[0];
      eb = b_req && !m_starv[1];
      if (ea && eb) m_owner = (m_last == 2) ? 1 : 2;
      else if (ea)  m_owner = 1;
      else if (eb)  m_owner = 2;
      m_cnt = 0;
    end else begin
      mine   = (m_owner == 1) ? a_req : b_req;
      other  = (m_owner == 1) ? b_req : a_req;
      strobe = (m_owner == 1) ? (a_write | a_read | a_reset) : (b_write | b_read | b_reset);
      if (!mine) begin
        m_last = m_owner; m_owner = 0; m_gap = 1;
      end else if (WD && m_cnt == HT - 1 && other) begin
        m_starv[m_owner - 1] = 1; m_to = 1;
        m_last = m_owner; m_owner = 0; m_gap = 1;
      end else if (strobe) begin
        m_cnt = 0;
      end else if (m_cnt < HT - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e = '0;
    e.a_gnt   = (m_owner == 1);
    e.b_gnt   = (m_owner == 2);
    e.a_rd    = rd_ready && m_owner == 1;
    e.a_wr    = wr_ready && m_owner == 1;
    e.b_rd    = rd_ready && m_owner == 2;
    e.b_wr    = wr_ready && m_owner == 2;
    e.rd_data = diRegDataOut;
    e.owner   = 2'(m_owner);
    e.to      = m_to;
    if (m_owner == 1) begin
      e.ep = a_ep_addr; e.ra = a_reg_addr; e.din = a_data;
      e.wr = a_write; e.rd = a_read; e.rs = a_reset;
    end else if (m_owner == 2) begin
      e.ep = b_ep_addr; e.ra = b_reg_addr; e.din = b_data;
      e.wr = b_write; e.rd = b_read; e.rs = b_reset;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge if_clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("a_gnt", 16'(a_gnt), 16'(e.a_gnt));
      chk("b_gnt", 16'(b_gnt), 16'(e.b_gnt));
      chk("a_rd_ready", 16'(a_rd_ready), 16'(e.a_rd));
      chk("a_wr_ready", 16'(a_wr_ready), 16'(e.a_wr));
      chk("b_rd_ready", 16'(b_rd_ready), 16'(e.b_rd));
      chk("b_wr_ready", 16'(b_wr_ready), 16'(e.b_wr));
      chk("rd_data", rd_data, e.rd_data);
      chk("diEpAddr", diEpAddr, e.ep);
      chk("diRegAddr", diRegAddr, e.ra);
      chk("diRegDataIn", diRegDataIn, e.din);
      chk("diWrite", 16'(diWrite), 16'(e.wr));
      chk("diRead", 16'(diRead), 16'(e.rd));
      chk("diReset", 16'(diReset), 16'(e.rs));
      chk("arb_owner", 16'(arb_owner), 16'(e.owner));
      chk("arb_timeout", 16'(arb_timeout), 16'(e.to));
    end
  end

  // Inputs are already applied (posedge+1); queue the expectation, then advance one edge.
  task automatic tick();
    q.push_back(expected());
    @(posedge if_clock);
    model_step();
    #1;
  endtask

  task automatic clear_strobes();
    a_write = 0; a_read = 0; a_reset = 0; b_write = 0; b_read = 0; b_reset = 0;
  endtask

  task automatic rand_cycles(input int n, input int strobe_pct, input bit allow_rst);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) a_req = ~a_req;
      if ($urandom_range(0, 9) == 0) b_req = ~b_req;
      a_write = ($urandom_range(0, 99) < strobe_pct);
      a_read  = ($urandom_range(0, 99) < strobe_pct);
      a_reset = ($urandom_range(0, 99) < strobe_pct / 4);
      b_write = ($urandom_range(0, 99) < strobe_pct);
      b_read  = ($urandom_range(0, 99) < strobe_pct);
      b_reset = ($urandom_range(0, 99) < strobe_pct / 4);
      a_ep_addr = 16'($urandom); a_reg_addr = 16'($urandom); a_data = 16'($urandom);
      b_ep_addr = 16'($urandom); b_reg_addr = 16'($urandom); b_data = 16'($urandom);
      diRegDataOut = 16'($urandom);
      rd_ready = 1'($urandom); wr_ready = 1'($urandom);
      arb_timeout_clr = ($urandom_range(0, 15) == 0);
      resetb = !(allow_rst && $urandom_range(0, 149) == 0);
      tick();
    end
    resetb = 1; arb_timeout_clr = 0;
  endtask

  initial begin
    resetb = 0;
    repeat (2) @(posedge if_clock);
    #1;
    model_reset();
    tick();

    // Single request from A with a visible endpoint address.
    resetb = 1; tick();
    a_req = 1; a_ep_addr = 16'h0012; tick();
    repeat (3) tick();
    // B tries to write while A owns.
    b_req = 1; b_write = 1; b_data = 16'hBEEF; a_data = 16'h5A5A; wr_ready = 1; tick();
    tick();
    clear_strobes();
    // A drops: handover, then B; B read with ready.
    a_req = 0; tick();
    repeat (2) tick();
    rd_ready = 1; b_read = 1; diRegDataOut = 16'h1234; tick();
    clear_strobes(); rd_ready = 0; wr_ready = 0;
    b_req = 0; tick();
    repeat (3) tick();
    // Tie from IDLE after B was last owner: A wins; second tie also to A after reset.
    a_req = 1; b_req = 1; repeat (4) tick();
    a_req = 0; repeat (4) tick();
    b_req = 0; repeat (3) tick();
    resetb = 0; tick();
    resetb = 1; a_req = 1; b_req = 1; repeat (3) tick();

    // Reset mid-write while A owns.
    b_req = 0; a_write = 1; a_data = 16'hCAFE; tick();
    resetb = 0; tick();
    resetb = 1; clear_strobes(); a_req = 0; repeat (2) tick();

    // Long idle ownership with a competitor, then without one.
    a_req = 1; repeat (2) tick();
    b_req = 1; repeat (30) tick();
    arb_timeout_clr = 1; tick();
    arb_timeout_clr = 0; b_req = 0; repeat (3) tick();
    a_req = 0; tick();
    a_req = 1; repeat (25) tick();
    a_req = 0; repeat (3) tick();

    rand_cycles(1500, 20, 1'b1);
    clear_strobes();
    rand_cycles(1500, 0, 1'b1);
    rand_cycles(1000, 5, 1'b0);

    @(negedge if_clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
